// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the five-stage pipeline front end.
package rv_pipe_pkg;

  // addi x0,x0,0 -- presented to decode whenever no fetched word is ready
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // One prefetched instruction together with the PC it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Sequential next-word PC, wraps modulo 2^32
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for prefetched words. Clear dominates push/pop.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A push into a full FIFO is accepted only if the head leaves this cycle
  assign w_push  = i_push & (~w_full | w_pop);

  assign o_dout  = r_mem[r_rd];
  assign o_count = r_count;

  // Pointer and occupancy update; reset and clear both empty the FIFO
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: owns the fetch PC, issues in-order word requests
// under a credit limit, buffers returned words and presents them to decode.
// A redirect flushes the FIFO and arms a drop counter so that responses to
// requests issued before the redirect are discarded on arrival.
module ifu_prefetch
  import rv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRValid,
  input  logic [31:0] ImemRData,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic [31:0] InstrF,
  output logic        InstrValidF
);

  localparam int          CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   r_reqpc;
  logic [31:0]   r_resppc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_occ;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_ent;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic          w_discard;
  logic [CW:0]   w_used;

  assign w_valid = (w_occ != '0);
  // Redirect squashes the head even if decode would otherwise take it
  assign w_pop   = ~stallF & w_valid & ~PCSrcE;

  // Credits: buffered words plus in-flight requests, net of this cycle's pop
  assign w_used  = {1'b0, w_occ} + {1'b0, r_out} - (CW + 1)'(w_pop);
  assign ImemReq  = ~reset & ~PCSrcE & (w_used < DEPTH_C);
  assign ImemAddr = r_reqpc;
  assign w_issue  = ImemReq & ImemGnt;

  // Stale responses (issued before a redirect) are consumed without a push
  assign w_discard = ImemRValid & (r_drop != '0);
  assign w_push    = ImemRValid & (r_drop == '0) & ~PCSrcE;

  assign w_push_ent.pc    = r_resppc;
  assign w_push_ent.instr = ImemRData;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (PCSrcE),
    .i_push  (w_push),
    .i_din   (w_push_ent),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_occ)
  );

  // Empty FIFO presents a bubble to decode
  assign InstrValidF = w_valid;
  assign InstrF      = w_valid ? w_head.instr : NOP_INSTR;
  assign PCF         = w_valid ? w_head.pc    : 32'h0;
  assign PCplus4F    = pc_inc(PCF);

  // PC and counter bookkeeping; redirect overrides every other event
  always_ff @(posedge clk) begin
    if (reset) begin
      r_reqpc  <= RESET_PC;
      r_resppc <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
    end else if (PCSrcE) begin
      r_reqpc  <= PCTargetE;
      r_resppc <= PCTargetE;
      r_out    <= r_out - CW'(ImemRValid);
      r_drop   <= r_out - CW'(ImemRValid);
    end else begin
      if (w_issue)   r_reqpc  <= pc_inc(r_reqpc);
      if (w_push)    r_resppc <= pc_inc(r_resppc);
      if (w_discard) r_drop   <= r_drop - CW'(1);
      r_out <= r_out + CW'(w_issue) - CW'(ImemRValid);
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: in-order latency-configurable memory, a queue-based
// reference model (buffered words + tagged in-flight requests), a directed
// vector table for the start-up/stall sequence, hand-written corner cases and
// a randomized soak.
module tb_ifu_prefetch;
  import rv_pipe_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stallF, PCSrcE, ImemGnt, ImemRValid;
  logic [31:0] PCTargetE, ImemRData;
  logic        ImemReq, InstrValidF;
  logic [31:0] ImemAddr, PCF, PCplus4F, InstrF;

  ifu_prefetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stallF(stallF), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemGnt(ImemGnt), .ImemRValid(ImemRValid), .ImemRData(ImemRData),
    .PCF(PCF), .PCplus4F(PCplus4F), .InstrF(InstrF), .InstrValidF(InstrValidF)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic stale; } infl_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic stl; logic gnt;
    logic exp_req; logic [31:0] exp_addr; logic exp_vld; logic [31:0] exp_pc;
  } vec_t;

  fetch_entry_t fq[$];
  infl_t        inq[$];
  mreq_t        mq[$];
  logic [31:0]  m_reqpc;
  int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  int checks = 0, failures = 0, n_disc = 0, n_pops = 0;
  logic        s_req, s_vld;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, check against model, advance model+memory
  task automatic step(input logic rst, input logic stl, input logic psrc,
                      input logic [31:0] tgt, input logic g);
    logic        vld, pop, ereq, rv_now;
    logic [31:0] epc, einstr;
    int          used, lat, due;
    infl_t        e;
    fetch_entry_t fe;
    mreq_t        mr;
    @(negedge clk);
    reset = rst; stallF = stl; PCSrcE = psrc; PCTargetE = tgt; ImemGnt = g;
    rv_now = !rst && mq.size() > 0 && mq[0].due <= cyc;
    ImemRValid = rv_now;
    ImemRData  = rv_now ? memf(mq[0].addr) : $urandom;
    #1;
    vld    = fq.size() > 0;
    epc    = vld ? fq[0].pc : 32'h0;
    einstr = vld ? fq[0].instr : NOP_INSTR;
    pop    = !stl && vld && !psrc;
    used   = fq.size() + inq.size() - (pop ? 1 : 0);
    ereq   = !rst && !psrc && (used < DEPTH);
    chk("InstrValidF", {31'b0, InstrValidF}, {31'b0, vld});
    chk("PCF", PCF, epc);
    chk("PCplus4F", PCplus4F, epc + 32'd4);
    chk("InstrF", InstrF, einstr);
    chk("ImemReq", {31'b0, ImemReq}, {31'b0, ereq});
    if (ereq) chk("ImemAddr", ImemAddr, m_reqpc);
    s_req = ImemReq; s_addr = ImemAddr; s_vld = InstrValidF; s_pc = PCF; s_instr = InstrF;
    // reference model
    if (rst) begin
      fq.delete(); inq.delete(); m_reqpc = RPC;
    end else if (psrc) begin
      fq.delete();
      if (rv_now && inq.size() > 0) begin void'(inq.pop_front()); n_disc++; end
      foreach (inq[i]) inq[i].stale = 1'b1;
      m_reqpc = tgt;
    end else begin
      if (pop) begin void'(fq.pop_front()); n_pops++; end
      if (rv_now && inq.size() > 0) begin
        e = inq.pop_front();
        if (e.stale) n_disc++;
        else begin fe.pc = e.pc; fe.instr = ImemRData; fq.push_back(fe); end
      end
      if (ereq && g) begin
        e.pc = m_reqpc; e.stale = 1'b0; inq.push_back(e);
        m_reqpc = m_reqpc + 32'd4;
      end
    end
    // memory
    if (rst) begin
      mq.delete(); last_due = 0;
    end else begin
      if (rv_now) void'(mq.pop_front());
      if (ImemReq && g) begin
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mr.addr = ImemAddr; mr.due = due; mq.push_back(mr);
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  vec_t vt[10];
  int   got, nd0;
  logic [31:0] a0;

  initial begin
    reset = 1'b1; stallF = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    ImemGnt = 1'b0; ImemRValid = 1'b0; ImemRData = 32'h0;
    m_reqpc = RPC;
    @(posedge clk);
    // reset cycles: bubble outputs, no request
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("rst_req", {31'b0, s_req}, 32'd0);
    chk("rst_pc", s_pc, 32'h0);
    chk("rst_instr", s_instr, NOP_INSTR);

    // start-up streaming with L=1 then a 3-cycle stall
    vt[0] = '{0, 1, 1, 32'h00, 0, 32'h00};
    vt[1] = '{0, 1, 1, 32'h04, 0, 32'h00};
    vt[2] = '{0, 1, 1, 32'h08, 1, 32'h00};
    vt[3] = '{0, 1, 1, 32'h0C, 1, 32'h04};
    vt[4] = '{1, 1, 0, 32'h10, 1, 32'h08};
    vt[5] = '{1, 1, 0, 32'h10, 1, 32'h08};
    vt[6] = '{1, 1, 0, 32'h10, 1, 32'h08};
    vt[7] = '{0, 1, 1, 32'h10, 1, 32'h08};
    vt[8] = '{0, 1, 1, 32'h14, 1, 32'h0C};
    vt[9] = '{0, 1, 1, 32'h18, 1, 32'h10};
    for (int i = 0; i < 10; i++) begin
      step(0, vt[i].stl, 0, 0, vt[i].gnt);
      chk($sformatf("vec%0d_req", i), {31'b0, s_req}, {31'b0, vt[i].exp_req});
      if (vt[i].exp_req) chk($sformatf("vec%0d_addr", i), s_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d_vld", i), {31'b0, s_vld}, {31'b0, vt[i].exp_vld});
      chk($sformatf("vec%0d_pc", i), s_pc, vt[i].exp_pc);
      if (vt[i].exp_vld) chk($sformatf("vec%0d_instr", i), s_instr, memf(vt[i].exp_pc));
    end

    // grant withheld 4 cycles: address holds, FIFO drains to a bubble
    step(0, 0, 0, 0, 0);
    a0 = s_addr;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      chk("nogrant_addr_hold", s_addr, a0);
      chk("nogrant_req_hold", {31'b0, s_req}, 32'd1);
    end
    chk("nogrant_drained_vld", {31'b0, s_vld}, 32'd0);
    chk("nogrant_drained_nop", s_instr, NOP_INSTR);

    // L=3, two in flight with empty FIFO, then redirect to 0x100
    lat_min = 3; lat_max = 3;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (inq.size() == 2 && fq.size() == 0) begin got = 1; break; end
      step(0, 0, 0, 0, 1);
    end
    chk("l3_two_inflight", got, 1);
    nd0 = n_disc;
    step(0, 0, 1, 32'h100, 1);
    step(0, 0, 0, 0, 1);
    chk("redir_fifo_empty", {31'b0, s_vld}, 32'd0);
    got = 0;
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 0, 0, 1);
      if (s_vld) begin got = 1; break; end
    end
    chk("redir_got_valid", got, 1);
    chk("redir_first_pc", s_pc, 32'h100);
    chk("redir_first_instr", s_instr, memf(32'h100));
    chk("redir_discarded", n_disc - nd0, 2);

    // redirect coincident with a response and a stall
    lat_min = 2; lat_max = 2;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (mq.size() > 0 && mq[0].due <= cyc && inq.size() > 0) begin got = 1; break; end
      step(0, 0, 0, 0, 1);
    end
    chk("coinc_rv_found", got, 1);
    nd0 = n_disc + inq.size();
    step(0, 1, 1, 32'h200, 1);
    chk("coinc_req_low", {31'b0, s_req}, 32'd0);
    step(0, 0, 0, 0, 1);
    chk("coinc_next_req", {31'b0, s_req}, 32'd1);
    chk("coinc_next_addr", s_addr, 32'h200);
    got = 0;
    for (int k = 0; k < 30; k++) begin
      step(0, 0, 0, 0, 1);
      if (s_vld) begin got = 1; break; end
    end
    chk("coinc_got_valid", got, 1);
    chk("coinc_first_pc", s_pc, 32'h200);
    chk("coinc_discarded", n_disc, nd0);

    // reset mid-stream with a full FIFO
    for (int k = 0; k < 8; k++) step(0, 1, 0, 0, 1);
    chk("midrst_full", fq.size(), DEPTH);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("midrst_vld", {31'b0, s_vld}, 32'd0);
    chk("midrst_instr", s_instr, NOP_INSTR);
    chk("midrst_pc", s_pc, 32'h0);
    chk("midrst_req", {31'b0, s_req}, 32'd1);
    chk("midrst_addr", s_addr, RPC);

    // randomized soak
    lat_min = 1; lat_max = 4;
    nd0 = n_pops;
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 24) == 0), ($urandom & 32'hFFFF_FFFC),
           ($urandom_range(0, 3) != 0));
    end
    chk("soak_progress", {31'b0, (n_pops - nd0) > 300}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
